// File: rtl/spi_slave_core.sv
// SPI slave with pins oversampled in the system clock domain: all four modes,
// configurable word width/bit order, single-entry TX buffer, RX strobe and error flags.
module spi_slave_core #(
  parameter int DATA_WIDTH  = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_load_i,
  output logic                  tx_ready_o,
  output logic                  tx_underrun_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic                  rx_overrun_o,
  input  logic                  rx_ack_i,
  output logic                  busy_o,
  input  logic                  spi_clk_i,
  input  logic                  mosi_i,
  input  logic                  cs_i,
  output logic                  miso_o,
  output logic                  miso_oe_o
);
  localparam int   CW     = $clog2(DATA_WIDTH);
  localparam logic CPOL_B = (CPOL != 0);
  localparam logic CPHA_B = (CPHA != 0);
  localparam logic MSB_B  = (MSB_FIRST != 0);

  typedef enum logic {IDLE, ACTIVE} state_e;
  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, cs_prev_q;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d, rx_data_q, rx_data_d;
  logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d, buf_q, buf_d;
  logic                  rx_valid_q, rx_valid_d, rx_pend_q, rx_pend_d, rx_ovr_q, rx_ovr_d;
  logic                  buf_full_q, buf_full_d, underrun_q, underrun_d, miso_q, miso_d;

  // Sync chains reset to the idle pin levels so reset release makes no false edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_sync_q <= {SYNC_STAGES{CPOL_B}};
      cs_sync_q   <= {SYNC_STAGES{1'b1}};
      mosi_sync_q <= '0;
      sclk_prev_q <= CPOL_B;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  logic sclk_s, cs_s, mosi_s;
  logic sclk_chg, lead_e, trail_e, cs_fall, cs_rise;
  logic edges_ok, sample_e, shift_e, word_start, last_bit;
  logic [DATA_WIDTH-1:0] rx_shift, tx_src;

  assign sclk_s   = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_chg = sclk_s ^ sclk_prev_q;
  assign lead_e   = sclk_chg & (sclk_s != CPOL_B);
  assign trail_e  = sclk_chg & (sclk_s == CPOL_B);
  assign cs_fall  = ~cs_s & cs_prev_q;
  assign cs_rise  = cs_s & ~cs_prev_q;

  // A deselect in the same cycle as a clock edge wins; the edge is dropped.
  assign edges_ok = (state_q == ACTIVE) & ~cs_rise;
  assign sample_e = edges_ok & (CPHA_B ? trail_e : lead_e);
  assign shift_e  = edges_ok & (CPHA_B ? lead_e : trail_e);
  assign last_bit = (cnt_q == CW'(DATA_WIDTH-1));
  // With CPHA=0 a shift edge seen at count 0 can only follow a completed word.
  assign word_start = CPHA_B ? (shift_e & (cnt_q == '0))
                             : ((state_q == IDLE) & cs_fall) | (shift_e & (cnt_q == '0));

  assign rx_shift = MSB_B ? {rx_sr_q[DATA_WIDTH-2:0], mosi_s}
                          : {mosi_s, rx_sr_q[DATA_WIDTH-1:1]};
  assign tx_src   = buf_full_q ? buf_q : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall) state_d = ACTIVE;
      ACTIVE:  if (cs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_pend_d  = rx_pend_q;
    rx_ovr_d   = rx_ovr_q;
    tx_sr_d    = tx_sr_q;
    miso_d     = miso_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    underrun_d = 1'b0;

    if (rx_ack_i) begin
      rx_pend_d = 1'b0;
      rx_ovr_d  = 1'b0;
    end
    if (sample_e) begin
      rx_sr_d = rx_shift;
      if (last_bit) begin
        cnt_d      = '0;
        rx_data_d  = rx_shift;
        rx_valid_d = 1'b1;
        rx_pend_d  = 1'b1;
        if (rx_pend_q && !rx_ack_i) rx_ovr_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (word_start) begin
      tx_sr_d    = tx_src;
      miso_d     = MSB_B ? tx_src[DATA_WIDTH-1] : tx_src[0];
      underrun_d = ~buf_full_q;
      buf_full_d = 1'b0;
    end else if (shift_e) begin
      tx_sr_d = MSB_B ? (tx_sr_q << 1) : (tx_sr_q >> 1);
      miso_d  = MSB_B ? tx_sr_q[DATA_WIDTH-2] : tx_sr_q[1];
    end
    // Evaluated after the transfer so a load coinciding with an empty-buffer start is kept.
    if (tx_load_i && !buf_full_q) begin
      buf_d      = tx_data_i;
      buf_full_d = 1'b1;
    end

    if ((state_q == IDLE) && cs_fall) begin
      cnt_d   = '0;
      rx_sr_d = '0;
    end
    if ((state_q == ACTIVE) && cs_rise) begin
      cnt_d   = '0;
      rx_sr_d = '0;
      miso_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_pend_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
      tx_sr_q    <= '0;
      miso_q     <= 1'b0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_pend_q  <= rx_pend_d;
      rx_ovr_q   <= rx_ovr_d;
      tx_sr_q    <= tx_sr_d;
      miso_q     <= miso_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      underrun_q <= underrun_d;
    end
  end

  assign tx_ready_o    = ~buf_full_q;
  assign tx_underrun_o = underrun_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign rx_overrun_o  = rx_ovr_q;
  assign busy_o        = (state_q == ACTIVE);
  assign miso_oe_o     = busy_o;
  assign miso_o        = miso_q & busy_o;
endmodule
